ysyx_23060096_ifu: RTL and testbench
====================================

Name: ysyx_23060096_ifu

Overview:
- Instruction fetch unit of the NPC core; sits directly upstream of the control generator / decode stage.
- Owns the PC and issues one outstanding read at a time to instruction memory over a valid/ready request channel plus a response channel.
- Presents the fetched instruction and its PC to decode with a valid/ready handshake.
- Accepts PC redirects (branch/jump/trap) from execute and discards wrong-path fetches.

Parameters:
- RESET_PC, 32'h8000_0000, PC value loaded on reset.
- XLEN, 32, width of PC and instruction data.

Ports:
- clk  input  1  core clock
- rst  input  1  synchronous active-high reset
- imem_req_valid  output  1  fetch request valid
- imem_req_ready  input  1  memory accepts request
- imem_req_addr  output  XLEN  fetch address, word aligned
- imem_rsp_valid  input  1  read data valid; at most one per accepted request
- imem_rsp_data  input  XLEN  instruction word
- imem_rsp_err  input  1  access fault for this response
- inst_valid  output  1  instruction available to decode
- inst_ready  input  1  decode accepts instruction
- inst  output  XLEN  instruction word, feeds op/func3/func7 decode
- inst_pc  output  XLEN  PC of inst
- inst_fault  output  1  instruction fetch access fault
- redirect_valid  input  1  next PC override from execute
- redirect_pc  input  XLEN  redirect target

Behaviour:
- Clock and reset: clk only; rst is synchronous, active-high, sampled on posedge clk.
- Reset state:
  - pc=RESET_PC, state=S_IDLE, kill=0.
  - imem_req_valid=0, inst_valid=0, inst=0, inst_pc=0, inst_fault=0.
  - imem_req_addr=pc.
- States:
  - S_IDLE: one cycle after reset, then -> S_REQ.
  - S_REQ: imem_req_valid=1, imem_req_addr=pc. Address is stable while valid is high. On imem_req_ready=1 -> S_RESP.
  - S_RESP: waits for imem_rsp_valid.
    - If kill=0: latch data, err and pc into inst, inst_fault and inst_pc, then -> S_OUT.
    - If kill=1: drop the response, clear kill, -> S_REQ.
  - S_OUT: inst_valid = ~redirect_valid. Outputs are held stable until the transfer completes.
    - On inst_valid & inst_ready: pc <= pc+4, -> S_REQ.
- Latency: the first request is issued 1 cycle after rst deasserts. With zero-wait memory (ready=1, response the next cycle) throughput is one instruction per 3 cycles; no request overlap.
- Redirect handling, in any state except S_IDLE. Redirect wins over every other event in the same cycle. pc <= {redirect_pc[XLEN-1:2],2'b00}, so low bits are cleared.
  - S_REQ without handshake that cycle: set kill=1. The request stays up with the old address, and its response is dropped.
  - S_REQ with handshake the same cycle: -> S_RESP with kill=1.
  - S_RESP: kill=1. If the response arrives the same cycle, it is dropped immediately, kill stays 0, -> S_REQ.
  - S_OUT: the held instruction is discarded, no transfer occurs (inst_valid forced 0), -> S_REQ.
- PC arithmetic: wraps modulo 2^XLEN (32'hFFFF_FFFC+4 = 0).
- Fault handling: a fault response is delivered normally with inst_fault=1; the IFU does not stall or trap on it.
- Response ordering: imem_rsp_valid outside S_RESP is a protocol violation. The IFU ignores it, and the bench asserts it never occurs.
- rst mid-transaction returns everything to the reset state. Memory shares the same rst, so there are no stale responses.

Optional Feature:
- Macro: YSYX_23060096_IFU_PERF_EN.
- Defined: adds outputs perf_fetch_cnt[63:0] and perf_stall_cnt[63:0], both reset to 0.
  - perf_fetch_cnt: instructions transferred to decode.
  - perf_stall_cnt: cycles in S_REQ/S_RESP, plus cycles in S_OUT with inst_ready=0.
  - Both wrap at 2^64.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package/header ysyx_23060096_defs:
  - fetch-state encoding (S_IDLE=2'd0, S_REQ=2'd1, S_RESP=2'd2, S_OUT=2'd3)
  - RESET_PC default
  - INST_NOP=32'h0000_0013
- Sub-module ysyx_23060096_pc_reg: PC register with reset, redirect and +4 enable. All remaining logic is in the top FSM.

Test Plan:
- Reset, then memory with ready=1 and 1-cycle response returning 32'h0010_0093 -> request addr 32'h8000_0000; inst=32'h0010_0093, inst_pc=32'h8000_0000; next request at 32'h8000_0004.
- Backpressure: hold inst_ready=0 for 5 cycles in S_OUT -> inst/inst_pc stable, no new request issued; accepted on ready, then request at pc+4.
- Redirect in S_RESP to 32'h8000_0102 -> late response dropped (inst_valid never high for it); next request addr 32'h8000_0100.
- Redirect and inst_ready together in S_OUT -> no transfer, pc=redirect target, next request carries it.
- Response with imem_rsp_err=1 at 32'h8000_0010 -> inst_fault=1, inst_pc=32'h8000_0010; the next fetch has inst_fault=0.
- rst asserted in S_RESP -> all outputs 0 next cycle; after release the request restarts at 32'h8000_0000.

Source files
------------

// File: rtl/ysyx_23060096_defs.sv
// Shared definitions for the NPC instruction fetch unit.
//   fetch_state_e    : IFU fetch FSM encoding
//   RESET_PC_DEFAULT : PC loaded on reset unless overridden
//   INST_NOP         : canonical addi x0,x0,0
package ysyx_23060096_defs;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_OUT  = 2'd3
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam logic [31:0] INST_NOP         = 32'h0000_0013;

endpackage

// File: rtl/ysyx_23060096_pc_reg.sv
// Program counter register.
//   clk, rst     : clock, synchronous active-high reset (loads RESET_PC)
//   redirect_en  : load redirect_pc with the low two bits cleared (wins)
//   redirect_pc  : redirect target
//   inc_en       : advance by 4, wrapping modulo 2^XLEN
//   pc           : current PC
module ysyx_23060096_pc_reg
  import ysyx_23060096_defs::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_en,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            inc_en,
  output logic [XLEN-1:0] pc
);

  logic [XLEN-1:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (redirect_en)  pc_d = redirect_pc & ~XLEN'(3);
    else if (inc_en)  pc_d = pc_q + XLEN'(4);
  end

  always_ff @(posedge clk) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_d;
  end

  assign pc = pc_q;

endmodule

// File: rtl/ysyx_23060096_ifu.sv
// Instruction fetch unit: owns the PC, issues one outstanding read to
// instruction memory at a time and hands the word plus its PC to decode.
//   imem_req_*     : request channel (valid/ready, word-aligned address)
//   imem_rsp_*     : response channel (data, access-fault flag)
//   inst_*         : decode channel (valid/ready, word, PC, fault)
//   redirect_*     : next-PC override from execute, wins over everything
// Optional macro YSYX_23060096_IFU_PERF_EN adds perf_fetch_cnt and
// perf_stall_cnt (64-bit, wrapping).
module ysyx_23060096_ifu
  import ysyx_23060096_defs::*;
#(
  parameter int          XLEN     = 32,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            imem_rsp_err,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            inst_fault,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
`ifdef YSYX_23060096_IFU_PERF_EN
  ,
  output logic [63:0]     perf_fetch_cnt,
  output logic [63:0]     perf_stall_cnt
`endif
);

  fetch_state_e    state_q, state_d;
  logic            kill_q, kill_d;
  logic [XLEN-1:0] hold_addr_q, hold_addr_d;
  logic [XLEN-1:0] inst_q, inst_d;
  logic [XLEN-1:0] inst_pc_q, inst_pc_d;
  logic            fault_q, fault_d;
  logic [XLEN-1:0] pc;
  logic            redir;
  logic            xfer;

  // Redirects are ignored only during the post-reset idle cycle.
  assign redir = redirect_valid & (state_q != S_IDLE);
  assign xfer  = inst_valid & inst_ready;

  ysyx_23060096_pc_reg #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC[XLEN-1:0])
  ) u_pc (
    .clk         (clk),
    .rst         (rst),
    .redirect_en (redir),
    .redirect_pc (redirect_pc),
    .inc_en      (xfer),
    .pc          (pc)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      kill_q      <= 1'b0;
      hold_addr_q <= '0;
      inst_q      <= '0;
      inst_pc_q   <= '0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      kill_q      <= kill_d;
      hold_addr_q <= hold_addr_d;
      inst_q      <= inst_d;
      inst_pc_q   <= inst_pc_d;
      fault_q     <= fault_d;
    end
  end

  // Next state
  always_comb begin
    state_d     = state_q;
    kill_d      = kill_q;
    hold_addr_d = hold_addr_q;
    inst_d      = inst_q;
    inst_pc_d   = inst_pc_q;
    fault_d     = fault_q;
    unique case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        // Snapshot the address while it is live so a redirect during a
        // pending request cannot move it; the killed request keeps it.
        if (!kill_q)        hold_addr_d = pc;
        if (redir)          kill_d      = 1'b1;
        if (imem_req_ready) state_d     = S_RESP;
      end
      S_RESP: begin
        if (imem_rsp_valid) begin
          if (kill_q || redir) begin
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            inst_d    = imem_rsp_data;
            inst_pc_d = pc;
            fault_d   = imem_rsp_err;
            state_d   = S_OUT;
          end
        end else if (redir) begin
          kill_d = 1'b1;
        end
      end
      S_OUT: if (redir || inst_ready) state_d = S_REQ;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    imem_req_valid = (state_q == S_REQ);
    imem_req_addr  = (state_q == S_REQ && kill_q) ? hold_addr_q : pc;
    inst_valid     = (state_q == S_OUT) && !redirect_valid;
  end

  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign inst_fault = fault_q;

`ifdef YSYX_23060096_IFU_PERF_EN
  logic [63:0] fetch_cnt_q, fetch_cnt_d;
  logic [63:0] stall_cnt_q, stall_cnt_d;
  logic        stall;

  assign stall = (state_q == S_REQ) || (state_q == S_RESP) ||
                 ((state_q == S_OUT) && !inst_ready);

  always_comb begin
    fetch_cnt_d = fetch_cnt_q + {63'd0, xfer};
    stall_cnt_d = stall_cnt_q + {63'd0, stall};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ysyx_23060096_ifu.sv
// Self-checking bench for ysyx_23060096_ifu: directed scenarios followed by
// randomized memory timing, decode backpressure and redirects, checked
// against a fetch-stream reference model and a one-outstanding memory model.
module tb_ysyx_23060096_ifu;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk;
  logic        rst;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        inst_valid, inst_ready;
  logic [31:0] inst, inst_pc;
  logic        inst_fault;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  ysyx_23060096_ifu dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .imem_rsp_err   (imem_rsp_err),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_fault     (inst_fault),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
  endtask

  // Memory contents: a fixed hash, with one known word and sparse faults.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'h0010_0093;
    return a * 32'h9E37_79B9 + 32'd1;
  endfunction

  function automatic logic mem_fault(input logic [31:0] a);
    return (a == 32'h8000_0010) || (a[31:28] == 4'h1 && a[4:2] == 3'd5);
  endfunction

  // Stimulus knobs
  logic        drv_rst = 1'b1;
  logic        drv_inst_ready = 1'b1;
  logic        drv_redirect = 1'b0;
  logic [31:0] drv_redirect_pc = '0;
  logic        rand_mem = 1'b0;
  int          fixed_delay = 1;

  // Memory model
  logic        pend = 1'b0;
  logic [31:0] pend_addr = '0;
  int          pend_cnt = 0;

  // Reference model
  logic [31:0] exp_pc = RST_PC;
  logic        stale_allow = 1'b0;
  logic        started = 1'b0;
  logic        prev_hold = 1'b0;
  logic [31:0] prev_addr = '0;

  // Per-tick events
  logic        ev_req, ev_fire, ev_valid;
  logic [31:0] last_req_addr, last_fire_pc;
  logic        last_fire_fault;
  int          fire_cnt = 0;

  initial begin
    rst = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
    imem_rsp_data = '0; imem_rsp_err = 1'b0; inst_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
  end

  // One clock: drive inputs at negedge, settle, observe what the next
  // posedge will see and advance the models accordingly.
  task automatic tick();
    logic rsp_now;
    @(negedge clk);
    rst = drv_rst;
    rsp_now = 1'b0;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0; imem_rsp_err = 1'b0;
    if (drv_rst) pend = 1'b0;
    else if (pend) begin
      if (pend_cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(pend_addr);
        imem_rsp_err   = mem_fault(pend_addr);
        pend = 1'b0; rsp_now = 1'b1;
      end else pend_cnt--;
    end
    imem_req_ready = rand_mem ? ($urandom_range(0, 2) != 0) : 1'b1;
    inst_ready     = drv_inst_ready;
    redirect_valid = drv_redirect;
    redirect_pc    = drv_redirect_pc;
    #1;
    ev_req = 1'b0; ev_fire = 1'b0; ev_valid = inst_valid;
    if (drv_rst) begin
      exp_pc = RST_PC; stale_allow = 1'b0; started = 1'b0; prev_hold = 1'b0;
      return;
    end
    if (rsp_now) chk("rsp_only_in_resp", {imem_req_valid, inst_valid}, 2'b00);
    if (drv_redirect) chk("redirect_blocks_valid", inst_valid, 1'b0);
    if (prev_hold && imem_req_valid) chk("req_addr_stable", imem_req_addr, prev_addr);
    prev_hold = imem_req_valid & ~imem_req_ready;
    prev_addr = imem_req_addr;
    if (imem_req_valid) started = 1'b1;
    if (imem_req_valid && imem_req_ready) begin
      if (!stale_allow) chk("req_addr", imem_req_addr, exp_pc);
      stale_allow = 1'b0;
      pend = 1'b1; pend_addr = imem_req_addr;
      pend_cnt = (rand_mem ? int'($urandom_range(1, 3)) : fixed_delay) - 1;
      ev_req = 1'b1; last_req_addr = imem_req_addr;
    end
    if (inst_valid && inst_ready) begin
      chk("inst_pc", inst_pc, exp_pc);
      chk("inst", inst, mem_word(exp_pc));
      chk("inst_fault", inst_fault, mem_fault(exp_pc));
      exp_pc = exp_pc + 32'd4;
      ev_fire = 1'b1; last_fire_pc = inst_pc; last_fire_fault = inst_fault;
      fire_cnt++;
    end
    if (drv_redirect) begin
      exp_pc = {drv_redirect_pc[31:2], 2'b00};
      stale_allow = 1'b1;
    end
  endtask

  task automatic wait_req(input string tag);
    for (int n = 0; n < 100; n++) begin
      tick();
      if (ev_req) break;
    end
    chk(tag, ev_req, 1'b1);
  endtask

  task automatic wait_fire(input string tag);
    for (int n = 0; n < 100; n++) begin
      tick();
      if (ev_fire) break;
    end
    chk(tag, ev_fire, 1'b1);
  endtask

  task automatic wait_valid(input string tag);
    for (int n = 0; n < 100; n++) begin
      tick();
      if (ev_valid) break;
    end
    chk(tag, ev_valid, 1'b1);
  endtask

  initial begin
    logic [31:0] cap_inst, cap_pc;
    int          seen_valid;

    // Reset state
    drv_rst = 1'b1;
    tick(); tick();
    chk("rst_req_valid", imem_req_valid, 1'b0);
    chk("rst_inst_valid", inst_valid, 1'b0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    chk("rst_inst_fault", inst_fault, 1'b0);
    chk("rst_req_addr", imem_req_addr, RST_PC);

    // First fetch: one idle cycle, then request at the reset PC
    drv_rst = 1'b0; drv_inst_ready = 1'b1; fixed_delay = 1;
    tick();
    chk("idle_cycle_no_req", imem_req_valid, 1'b0);
    tick();
    chk("first_req_valid", imem_req_valid, 1'b1);
    chk("first_req_addr", imem_req_addr, 32'h8000_0000);
    wait_fire("t1_fire");
    chk("t1_inst", last_fire_pc == 32'h8000_0000 && inst == 32'h0010_0093, 1'b1);
    wait_req("t1_next_req");
    chk("t1_next_addr", last_req_addr, 32'h8000_0004);

    // Backpressure: held outputs, no new request
    drv_inst_ready = 1'b0;
    wait_valid("t2_valid");
    cap_inst = inst; cap_pc = inst_pc;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t2_hold", {inst_valid, imem_req_valid, inst == cap_inst, inst_pc == cap_pc}, 4'b1011);
    end
    drv_inst_ready = 1'b1;
    tick();
    chk("t2_accept", ev_fire, 1'b1);
    wait_req("t2_next_req");
    chk("t2_next_addr", last_req_addr, cap_pc + 32'd4);

    // Redirect while waiting for a slow response
    fixed_delay = 3;
    wait_req("t3_req");
    drv_redirect = 1'b1; drv_redirect_pc = 32'h8000_0102;
    tick();
    drv_redirect = 1'b0;
    seen_valid = 0;
    for (int n = 0; n < 100; n++) begin
      tick();
      if (ev_valid) seen_valid++;
      if (ev_req) break;
    end
    chk("t3_req_seen", ev_req, 1'b1);
    chk("t3_dropped", seen_valid, 0);
    chk("t3_redirect_addr", last_req_addr, 32'h8000_0100);

    // Redirect and inst_ready together in S_OUT
    fixed_delay = 1; drv_inst_ready = 1'b0;
    wait_valid("t4_valid");
    drv_inst_ready = 1'b1; drv_redirect = 1'b1; drv_redirect_pc = 32'h8000_0200;
    tick();
    chk("t4_no_xfer", {inst_valid, ev_fire}, 2'b00);
    drv_redirect = 1'b0;
    wait_req("t4_req");
    chk("t4_redirect_addr", last_req_addr, 32'h8000_0200);

    // Fault response, then a clean one
    drv_redirect = 1'b1; drv_redirect_pc = 32'h8000_0010;
    tick();
    drv_redirect = 1'b0;
    wait_fire("t5_fire");
    chk("t5_fault_pc", last_fire_pc, 32'h8000_0010);
    chk("t5_fault", last_fire_fault, 1'b1);
    wait_fire("t5_fire2");
    chk("t5_clean_pc", last_fire_pc, 32'h8000_0014);
    chk("t5_clean", last_fire_fault, 1'b0);

    // Reset while a response is outstanding
    fixed_delay = 3;
    wait_req("t6_req");
    drv_rst = 1'b1;
    tick();
    drv_rst = 1'b0;
    tick();
    chk("t6_outputs", {imem_req_valid, inst_valid, inst_fault, inst, inst_pc}, 67'd0);
    chk("t6_addr", imem_req_addr, RST_PC);
    wait_req("t6_restart");
    chk("t6_restart_addr", last_req_addr, 32'h8000_0000);

    // Randomized traffic
    rand_mem = 1'b1;
    fire_cnt = 0;
    for (int i = 0; i < 4000; i++) begin
      drv_inst_ready = ($urandom_range(0, 3) != 0);
      drv_redirect   = started && ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 3))
        0:       drv_redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        1:       drv_redirect_pc = {4'h1, 28'($urandom)};
        default: drv_redirect_pc = $urandom;
      endcase
      tick();
    end
    drv_redirect = 1'b0;
    chk("rand_progress", fire_cnt > 100, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
